traffic_light_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/traffic_flash_divider.sv | 32 +++
 rtl/traffic_light_monitor.sv | 136 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: lamp phases, fault codes
// and the monitor state machine.
package traffic_pkg;

    // Values match the controller's own state encoding.
    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    localparam logic [2:0] FC_NONE   = 3'd0;
    localparam logic [2:0] FC_ONEHOT = 3'd1;
    localparam logic [2:0] FC_ORDER  = 3'd2;
    localparam logic [2:0] FC_SHORT  = 3'd3;
    localparam logic [2:0] FC_LONG   = 3'd4;

    // Lamp vectors are packed as {red, yellow, green}.
    localparam logic [2:0] LAMPS_RED    = 3'b100;
    localparam logic [2:0] LAMPS_YELLOW = 3'b010;
    localparam logic [2:0] LAMPS_GREEN  = 3'b001;

    function automatic phase_t lamps_phase(input logic [2:0] lamps);
        case (lamps)
            LAMPS_GREEN:  return PH_GREEN;
            LAMPS_YELLOW: return PH_YELLOW;
            default:      return PH_RED;
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:   return PH_GREEN;
            PH_GREEN: return PH_YELLOW;
            default:  return PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_flash_divider.sv
// Half-period divider for the fail-safe flashing red; output parks high
// while not running so flashing always starts with the lamp on.
module traffic_flash_divider #(
    parameter int FLASH_HALF = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic flash
);

    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] LAST = FW'(FLASH_HALF - 1);

    logic [FW-1:0] r_cnt;
    logic          r_flash;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_cnt   <= '0;
            r_flash <= 1'b1;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_flash <= ~r_flash;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign flash = r_flash;

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor behind the traffic light controller: checks one-hot lamps,
// phase order and dwell length, forwards lamps one cycle late, flashes red on fault.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int RED_TICKS    = 32,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 7,
    parameter int FLASH_HALF   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       fault_clear,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       in_sync,
    output logic [1:0] dbg_state
);

    localparam int MAX_RY = (RED_TICKS > YELLOW_TICKS) ? RED_TICKS : YELLOW_TICKS;
    localparam int MAX_T  = (MAX_RY > GREEN_TICKS) ? MAX_RY : GREEN_TICKS;
    localparam int CNT_W  = $clog2(MAX_T + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_t       r_state;
    logic [2:0]       r_prev;
    logic [2:0]       r_lamps;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_code;

    logic [2:0]       w_lamps;
    logic             w_onehot;
    logic             w_change;
    phase_t           w_prev_phase;
    phase_t           w_cur_phase;
    logic [CNT_W-1:0] w_exp;
    logic [2:0]       w_code;
    logic             w_flash;

    assign w_lamps      = {red, yellow, green};
    assign w_onehot     = (w_lamps == LAMPS_RED) || (w_lamps == LAMPS_YELLOW) ||
                          (w_lamps == LAMPS_GREEN);
    assign w_change     = (w_lamps != r_prev);
    assign w_prev_phase = lamps_phase(r_prev);
    assign w_cur_phase  = lamps_phase(w_lamps);

    always_comb begin
        w_exp = CNT_W'(RED_TICKS);
        case (w_prev_phase)
            PH_GREEN:  w_exp = CNT_W'(GREEN_TICKS);
            PH_YELLOW: w_exp = CNT_W'(YELLOW_TICKS);
            default:   w_exp = CNT_W'(RED_TICKS);
        endcase
    end

    // Priority chain: one-hot beats order beats short dwell beats long dwell.
    always_comb begin
        w_code = FC_NONE;
        if (!w_onehot) begin
            w_code = FC_ONEHOT;
        end else if (r_state == ST_RUN) begin
            if (w_change && (w_cur_phase != next_phase(w_prev_phase))) begin
                w_code = FC_ORDER;
            end else if (w_change && (r_cnt < w_exp)) begin
                w_code = FC_SHORT;
            end else if (!w_change && enable && (r_cnt == w_exp)) begin
                w_code = FC_LONG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SYNC;
            r_prev  <= LAMPS_RED;
            r_lamps <= LAMPS_RED;
            r_cnt   <= '0;
            r_code  <= FC_NONE;
        end else begin
            r_prev  <= w_lamps;
            r_lamps <= w_lamps;
            if (w_change) begin
                r_cnt <= enable ? CNT_W'(1) : '0;
            end else if (enable && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                ST_SYNC: begin
                    if (w_code != FC_NONE) begin
                        r_state <= ST_FAULT;
                        r_code  <= w_code;
                    end else if (r_prev == LAMPS_RED && w_lamps == LAMPS_GREEN) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_code != FC_NONE) begin
                        r_state <= ST_FAULT;
                        r_code  <= w_code;
                    end
                end
                default: begin
                    if (fault_clear && (w_lamps == LAMPS_RED)) begin
                        r_state <= ST_SYNC;
                        r_code  <= FC_NONE;
                    end
                end
            endcase
        end
    end

    traffic_flash_divider #(
        .FLASH_HALF(FLASH_HALF)
    ) u_flash (
        .clk  (clk),
        .reset(reset),
        .run  (r_state == ST_FAULT),
        .flash(w_flash)
    );

    assign fault       = (r_state == ST_FAULT);
    assign lamp_red    = fault ? w_flash : r_lamps[2];
    assign lamp_yellow = fault ? 1'b0 : r_lamps[1];
    assign lamp_green  = fault ? 1'b0 : r_lamps[0];
    assign fault_code  = r_code;
    assign in_sync     = (r_state == ST_RUN);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: normal cycling, each fault code,
// flash timing, fault clearing and reset during RUN.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       red;
    logic       yellow;
    logic       green;
    logic       fault_clear;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;
    logic       fault;
    logic [2:0] fault_code;
    logic       in_sync;
    logic [1:0] dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] RG = 3'b101;

    traffic_light_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .fault_clear(fault_clear),
        .lamp_red   (lamp_red),
        .lamp_yellow(lamp_yellow),
        .lamp_green (lamp_green),
        .fault      (fault),
        .fault_code (fault_code),
        .in_sync    (in_sync),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [2:0] l, input logic en, input logic clr);
        {red, yellow, green} = l;
        enable      = en;
        fault_clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(l, 1'b1, 1'b0);
            tick();
            chk("lamp_lag", {29'd0, lamp_red, lamp_yellow, lamp_green}, {29'd0, l});
            chk("no_fault", fault, 0);
        end
    endtask

    task automatic do_clear();
        set_in(R, 1'b0, 1'b1);
        tick();
        chk("clr_state", dbg_state, ST_SYNC);
        chk("clr_fault", fault, 0);
        chk("clr_code", fault_code, 0);
    endtask

    initial begin
        reset = 1'b1;
        set_in(R, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_lamps", {29'd0, lamp_red, lamp_yellow, lamp_green}, 32'd4);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_insync", in_sync, 0);
        chk("rst_state", dbg_state, ST_SYNC);
        reset = 1'b0;

        // Two full controller cycles after a partial first red.
        run_phase(R, 5);
        chk("sync_before_green", in_sync, 0);
        run_phase(G, 1);
        chk("insync_rise", in_sync, 1);
        chk("state_run", dbg_state, ST_RUN);
        run_phase(G, 19);
        run_phase(Y, 7);
        run_phase(R, 32);
        run_phase(G, 20);
        run_phase(Y, 7);
        run_phase(R, 32);
        chk("insync_hold", in_sync, 1);

        // Red+green while red is also at its limit: one-hot wins over long dwell.
        set_in(RG, 1'b1, 1'b0);
        tick();
        chk("f1_fault", fault, 1);
        chk("f1_code", fault_code, 1);
        chk("f1_state", dbg_state, ST_FAULT);
        chk("f1_lamps", {29'd0, lamp_red, lamp_yellow, lamp_green}, 32'd4);
        for (int i = 1; i < 48; i++) begin
            set_in(R, 1'b0, 1'b0);
            tick();
            chk("flash", lamp_red, ((i / 16) % 2 == 0) ? 1 : 0);
            chk("flash_others", {lamp_yellow, lamp_green}, 0);
        end

        set_in(Y, 1'b0, 1'b1);
        tick();
        chk("clr_ignored_fault", fault, 1);
        chk("clr_ignored_code", fault_code, 1);
        chk("clr_ignored_state", dbg_state, ST_FAULT);
        do_clear();
        chk("clr_lamp_red", lamp_red, 1);

        // Green straight back to red, also short: order wins.
        run_phase(R, 3);
        run_phase(G, 5);
        set_in(R, 1'b1, 1'b0);
        tick();
        chk("f2_fault", fault, 1);
        chk("f2_code", fault_code, 2);
        do_clear();

        run_phase(R, 2);
        run_phase(G, 19);
        set_in(Y, 1'b1, 1'b0);
        tick();
        chk("f3_fault", fault, 1);
        chk("f3_code", fault_code, 3);
        do_clear();

        run_phase(R, 2);
        run_phase(G, 20);
        run_phase(Y, 7);
        set_in(Y, 1'b1, 1'b0);
        tick();
        chk("f4_fault", fault, 1);
        chk("f4_code", fault_code, 4);
        chk("f4_yellow_forced", lamp_yellow, 0);
        do_clear();

        // Reset in the middle of green while in RUN.
        run_phase(R, 2);
        run_phase(G, 10);
        chk("pre_rst_run", dbg_state, ST_RUN);
        reset = 1'b1;
        set_in(G, 1'b1, 1'b0);
        tick();
        chk("mid_rst_lamps", {29'd0, lamp_red, lamp_yellow, lamp_green}, 32'd4);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_insync", in_sync, 0);
        chk("mid_rst_state", dbg_state, ST_SYNC);
        reset = 1'b0;
        run_phase(R, 4);
        run_phase(G, 20);
        chk("resync", in_sync, 1);
        // Idle tick at the limit and an idle first yellow cycle are not faults.
        set_in(G, 1'b0, 1'b0);
        tick();
        chk("idle_at_limit", fault, 0);
        set_in(Y, 1'b0, 1'b0);
        tick();
        chk("idle_change", fault, 0);
        run_phase(Y, 7);
        run_phase(R, 1);
        chk("end_code", fault_code, 0);
        chk("end_insync", in_sync, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
